img_rsz_blk_sched: RTL and testbench
====================================

# img_rsz_blk_sched

Block scheduler for the image resizer. It takes a frame-start request and dispatches resized-block jobs (X,Y) to the compute engine in raster order under an in-flight credit limit. It keeps the per-block executed scoreboard (`BlkIsExec`) that the forwarder reads, clears scoreboard entries on forwarder flushes, and pulses frame-done once every block has been computed and forwarded.

## Interface
Parameters:
- `RSZ_IMG_WIDTH_SIZE`, default 4: resized blocks per row (W).
- `RSZ_IMG_HEIGHT_SIZE`, default 4: resized blocks per column (H).
- `RSZ_IMG_WIDTH_IDX_W`, default `$clog2(RSZ_IMG_WIDTH_SIZE)`: X index width; must be ≥1.
- `RSZ_IMG_HEIGHT_IDX_W`, default `$clog2(RSZ_IMG_HEIGHT_SIZE)`: Y index width; must be ≥1.
- `MAX_INFLIGHT`, default 2: maximum number of jobs dispatched but not yet completed (≥1).

Ports:
- `Clk`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `FrmStartVld`  in  1  frame start request.
- `FrmStartRdy`  out  1  high only in IDLE.
- `JobVld`  out  1  job request to the compute engine.
- `JobRdy`  in  1  compute engine accepts the job.
- `JobPosX`  out  `RSZ_IMG_WIDTH_IDX_W`  job block X.
- `JobPosY`  out  `RSZ_IMG_HEIGHT_IDX_W`  job block Y.
- `DoneVld`  in  1  one-cycle completion pulse (no ready).
- `DonePosX`  in  `RSZ_IMG_WIDTH_IDX_W`  X of the completed block.
- `DonePosY`  in  `RSZ_IMG_HEIGHT_IDX_W`  Y of the completed block.
- `BlkIsExec`  out  `[W-1:0]` × `[H-1:0]` unpacked  executed scoreboard.
- `FlushBlkXMsk`  in  W  flush X mask from the forwarder.
- `FlushBlkYMsk`  in  H  flush Y mask from the forwarder.
- `FlushVld`  in  1  flush qualifier.
- `FrmDone`  out  1  one-cycle end-of-frame pulse.
- `Busy`  out  1  high whenever the state is not IDLE.
- `ErrDupDone`  out  1  sticky error flag.

## Operation
State machine:
- IDLE: `FrmStartRdy`=1. On `FrmStartVld` → DISPATCH. Scan counters reset to (0,0); `DoneCnt`=0.
- DISPATCH: `JobVld`=1 while `InFlight` < `MAX_INFLIGHT`. A handshake (`JobVld` && `JobRdy`) advances the raster scan: X++, and on X=W-1 wrap X to 0 and Y++. A handshake on (W-1,H-1) → DRAIN.
- DRAIN: `JobVld`=0. Move to DONE when all of the following hold: `DoneCnt`=W·H, `InFlight`=0, and every `BlkIsExec` bit is 0.
- DONE: `FrmDone`=1 for one cycle, then → IDLE.

Counters and scoreboard:
- `InFlight` (width `$clog2(MAX_INFLIGHT+1)`): +1 on a job handshake, −1 on `DoneVld`. Both in the same cycle leave it unchanged.
- `DoneCnt` (width `$clog2(W·H+1)`): increments on each `DoneVld`.
- On `DoneVld`, set `BlkIsExec[DonePosY][DonePosX]`.
- On `FlushVld`, clear every `BlkIsExec[y][x]` where `FlushBlkYMsk[y]` && `FlushBlkXMsk[x]`.
- Done and flush hitting the same entry in the same cycle: the set wins. The flush was derived from the prior state.

Error handling:
- `ErrDupDone` sets if `DoneVld` targets an entry already set, or arrives while `InFlight`=0. It stays set until `Reset`.
- A spurious `DoneVld` with `InFlight`=0 does not decrement `InFlight` and does not set the scoreboard.
- Out-of-range `DonePos` (X≥W or Y≥H) is ignored and sets `ErrDupDone`.

## Timing
- Reset values: all outputs 0 except `FrmStartRdy`=1. Scoreboard clear, counters 0, state IDLE, `ErrDupDone`=0.
- `Reset` mid-frame aborts immediately. Jobs still in flight are forgotten; later `DoneVld` pulses with `InFlight`=0 flag `ErrDupDone`.
- All outputs are registered.
- Start handshake at cycle T → `JobVld`=1 with (0,0) at T+1.
- `JobVld`/`JobPos` stay stable while `JobVld` && !`JobRdy`. `JobVld` does not drop without a handshake unless `Reset` is asserted.
- After a handshake at T, the next job appears at T+1 if credit remains. Back-to-back issue is 1 job/cycle.
- Credit returned by `DoneVld` at T allows `JobVld` at T+1.
- Scoreboard set or clear from an event at T is visible on `BlkIsExec` at T+1.
- DRAIN exit condition true at T → `FrmDone` at T+1 → `FrmStartRdy` at T+2.

## Test plan
- **Credit limit.** W=H=4, `MAX_INFLIGHT`=2, `JobRdy`=1, no `DoneVld` → exactly 2 jobs issued, (0,0) then (1,0); `JobVld` drops. A `DoneVld` for (0,0) → job (2,0) appears one cycle later.
- **Backpressure.** Hold `JobRdy`=0 for 5 cycles during job (3,0) → `JobPos` stays (3,0). The next handshake yields (0,1), checking the row wrap.
- **Full frame.** Complete all 16 blocks in order and flush each row with `FlushBlkXMsk`='1 and one-hot `FlushBlkYMsk` → `FrmDone` pulses exactly once; `DoneCnt`=16; `FrmStartRdy` returns.
- **Set/flush collision.** Same cycle: `DoneVld` at (2,1) and a flush with X=0b0100, Y=0b0010 → `BlkIsExec[1][2]`=1 afterwards. A flush alone on the next cycle clears it.
- **Duplicate done.** Send `DoneVld` for (0,0) twice → `ErrDupDone`=1 and stays 1. `InFlight` decrements only on the first.
- **Reset mid-frame.** Assert `Reset` in DRAIN with 3 scoreboard bits set → next cycle all outputs are at reset values and a new frame starts cleanly.

Source files
------------

// File: rtl/img_rsz_blk_sched.sv
// ----------------------------------------------------------------------------
// img_rsz_blk_sched
// Block scheduler for the image resizer. Dispatches resized-block jobs (X,Y)
// in raster order under an in-flight credit limit, keeps the per-block
// executed scoreboard read by the forwarder, clears it on forwarder flushes
// and pulses frame-done once every block is computed and forwarded.
//
// Ports
//   i_Clk, i_Reset            clock / synchronous active-high reset
//   i_FrmStartVld/o_FrmStartRdy  frame start handshake (ready only in IDLE)
//   o_JobVld/i_JobRdy         job handshake to the compute engine
//   o_JobPosX/o_JobPosY       job block coordinates
//   i_DoneVld, i_DonePosX/Y   one-cycle completion pulse with block coords
//   o_BlkIsExec[y][x]         executed scoreboard
//   i_FlushVld, i_FlushBlkXMsk/YMsk  scoreboard clear (X mask & Y mask)
//   o_FrmDone                 one-cycle end-of-frame pulse
//   o_Busy                    high whenever not IDLE
//   o_ErrDupDone              sticky bad-completion flag
// ----------------------------------------------------------------------------
module img_rsz_blk_sched #(
    parameter int unsigned RSZ_IMG_WIDTH_SIZE   = 4,
    parameter int unsigned RSZ_IMG_HEIGHT_SIZE  = 4,
    parameter int unsigned RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
    parameter int unsigned RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
    parameter int unsigned MAX_INFLIGHT         = 2
) (
    input  logic                            i_Clk,
    input  logic                            i_Reset,
    input  logic                            i_FrmStartVld,
    output logic                            o_FrmStartRdy,
    output logic                            o_JobVld,
    input  logic                            i_JobRdy,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  o_JobPosX,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] o_JobPosY,
    input  logic                            i_DoneVld,
    input  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  i_DonePosX,
    input  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] i_DonePosY,
    output logic [RSZ_IMG_WIDTH_SIZE-1:0]   o_BlkIsExec [RSZ_IMG_HEIGHT_SIZE-1:0],
    input  logic [RSZ_IMG_WIDTH_SIZE-1:0]   i_FlushBlkXMsk,
    input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]  i_FlushBlkYMsk,
    input  logic                            i_FlushVld,
    output logic                            o_FrmDone,
    output logic                            o_Busy,
    output logic                            o_ErrDupDone
);

    localparam int unsigned W      = RSZ_IMG_WIDTH_SIZE;
    localparam int unsigned H      = RSZ_IMG_HEIGHT_SIZE;
    localparam int unsigned XW     = RSZ_IMG_WIDTH_IDX_W;
    localparam int unsigned YW     = RSZ_IMG_HEIGHT_IDX_W;
    localparam int unsigned IFL_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned BLK_N  = W * H;
    localparam int unsigned DCNT_W = $clog2(BLK_N + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XW-1:0]       r_scan_x;
    logic [YW-1:0]       r_scan_y;
    logic [IFL_W-1:0]    r_inflight;
    logic [IFL_W-1:0]    w_inflight_nxt;
    logic [DCNT_W-1:0]   r_done_cnt;
    logic [W-1:0]        r_blk     [H-1:0];
    logic [W-1:0]        w_blk_nxt [H-1:0];
    logic                r_job_vld;
    logic                r_frm_start_rdy;
    logic                r_frm_done;
    logic                r_busy;
    logic                r_err;

    logic                w_job_vld_nxt;
    logic                w_frm_start_rdy_nxt;
    logic                w_frm_done_nxt;
    logic                w_busy_nxt;
    logic                w_hs;
    logic                w_start;
    logic                w_last_x;
    logic                w_last_blk;
    logic                w_done_in_rng;
    logic                w_done_hit;
    logic                w_done_ok;
    logic                w_done_err;
    logic                w_any_blk;
    logic                w_drain_exit;

    // Handshakes and raster-scan end detection
    assign w_hs       = r_job_vld & i_JobRdy;
    assign w_start    = (r_state == S_IDLE) & i_FrmStartVld;
    assign w_last_x   = (r_scan_x == XW'(W - 1));
    assign w_last_blk = w_last_x & (r_scan_y == YW'(H - 1));

    // Completion qualification: in range, credit outstanding, entry not yet set
    assign w_done_in_rng = (32'(i_DonePosX) < W) && (32'(i_DonePosY) < H);
    assign w_done_hit    = w_done_in_rng ? r_blk[i_DonePosY][i_DonePosX] : 1'b0;
    assign w_done_ok     = i_DoneVld & w_done_in_rng & (r_inflight != '0) & ~w_done_hit;
    assign w_done_err    = i_DoneVld & ~w_done_ok;

    // Credit counter next value; simultaneous issue and return cancel
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_hs && !w_done_ok) begin
            w_inflight_nxt = r_inflight + IFL_W'(1);
        end else if (!w_hs && w_done_ok) begin
            w_inflight_nxt = r_inflight - IFL_W'(1);
        end
    end

    // Scoreboard next value: flush clears from prior state, a same-cycle set wins
    always_comb begin
        w_any_blk = 1'b0;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                w_blk_nxt[y][x] = r_blk[y][x];
                if (i_FlushVld && i_FlushBlkYMsk[y] && i_FlushBlkXMsk[x]) begin
                    w_blk_nxt[y][x] = 1'b0;
                end
                if (w_done_ok && (i_DonePosY == YW'(y)) && (i_DonePosX == XW'(x))) begin
                    w_blk_nxt[y][x] = 1'b1;
                end
                w_any_blk = w_any_blk | r_blk[y][x];
            end
        end
    end

    assign w_drain_exit = (r_done_cnt == DCNT_W'(BLK_N)) && (r_inflight == '0) && !w_any_blk;

    // FSM state register
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (i_FrmStartVld)        w_state_nxt = S_DISPATCH;
            S_DISPATCH: if (w_hs && w_last_blk)   w_state_nxt = S_DRAIN;
            S_DRAIN:    if (w_drain_exit)         w_state_nxt = S_DONE;
            S_DONE:                               w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so they can be registered
    always_comb begin
        w_job_vld_nxt       = 1'b0;
        w_frm_start_rdy_nxt = 1'b0;
        w_frm_done_nxt      = 1'b0;
        w_busy_nxt          = 1'b1;
        unique case (w_state_nxt)
            S_IDLE: begin
                w_frm_start_rdy_nxt = 1'b1;
                w_busy_nxt          = 1'b0;
            end
            S_DISPATCH: w_job_vld_nxt  = (w_inflight_nxt < IFL_W'(MAX_INFLIGHT));
            S_DONE:     w_frm_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_job_vld       <= 1'b0;
            r_frm_start_rdy <= 1'b1;
            r_frm_done      <= 1'b0;
            r_busy          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_job_vld       <= w_job_vld_nxt;
            r_frm_start_rdy <= w_frm_start_rdy_nxt;
            r_frm_done      <= w_frm_done_nxt;
            r_busy          <= w_busy_nxt;
            r_err           <= r_err | w_done_err;
        end
    end

    // Raster scan, credit, completion count and scoreboard
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_scan_x   <= '0;
            r_scan_y   <= '0;
            r_inflight <= '0;
            r_done_cnt <= '0;
            r_blk      <= '{default: '0};
        end else begin
            r_inflight <= w_inflight_nxt;
            r_blk      <= w_blk_nxt;
            if (w_start) begin
                r_scan_x   <= '0;
                r_scan_y   <= '0;
                r_done_cnt <= '0;
            end else begin
                if (w_hs) begin
                    if (w_last_x) begin
                        r_scan_x <= '0;
                        r_scan_y <= w_last_blk ? '0 : r_scan_y + YW'(1);
                    end else begin
                        r_scan_x <= r_scan_x + XW'(1);
                    end
                end
                // Saturates so stray completions cannot wrap the count
                if (i_DoneVld && (r_done_cnt != DCNT_W'(BLK_N))) begin
                    r_done_cnt <= r_done_cnt + DCNT_W'(1);
                end
            end
        end
    end

    assign o_FrmStartRdy = r_frm_start_rdy;
    assign o_JobVld      = r_job_vld;
    assign o_JobPosX     = r_scan_x;
    assign o_JobPosY     = r_scan_y;
    assign o_BlkIsExec   = r_blk;
    assign o_FrmDone     = r_frm_done;
    assign o_Busy        = r_busy;
    assign o_ErrDupDone  = r_err;

endmodule

// File: tb/tb_img_rsz_blk_sched.sv
// ----------------------------------------------------------------------------
// tb_img_rsz_blk_sched
// Directed self-checking bench for img_rsz_blk_sched (W=H=4, MAX_INFLIGHT=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_img_rsz_blk_sched;

    logic       clk = 1'b0;
    logic       i_Reset;
    logic       i_FrmStartVld;
    logic       o_FrmStartRdy;
    logic       o_JobVld;
    logic       i_JobRdy;
    logic [1:0] o_JobPosX;
    logic [1:0] o_JobPosY;
    logic       i_DoneVld;
    logic [1:0] i_DonePosX;
    logic [1:0] i_DonePosY;
    logic [3:0] o_BlkIsExec [3:0];
    logic [3:0] i_FlushBlkXMsk;
    logic [3:0] i_FlushBlkYMsk;
    logic       i_FlushVld;
    logic       o_FrmDone;
    logic       o_Busy;
    logic       o_ErrDupDone;

    int total = 0;
    int bad   = 0;

    img_rsz_blk_sched #(
        .RSZ_IMG_WIDTH_SIZE  (4),
        .RSZ_IMG_HEIGHT_SIZE (4),
        .MAX_INFLIGHT        (2)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (i_Reset),
        .i_FrmStartVld  (i_FrmStartVld),
        .o_FrmStartRdy  (o_FrmStartRdy),
        .o_JobVld       (o_JobVld),
        .i_JobRdy       (i_JobRdy),
        .o_JobPosX      (o_JobPosX),
        .o_JobPosY      (o_JobPosY),
        .i_DoneVld      (i_DoneVld),
        .i_DonePosX     (i_DonePosX),
        .i_DonePosY     (i_DonePosY),
        .o_BlkIsExec    (o_BlkIsExec),
        .i_FlushBlkXMsk (i_FlushBlkXMsk),
        .i_FlushBlkYMsk (i_FlushBlkYMsk),
        .i_FlushVld     (i_FlushVld),
        .o_FrmDone      (o_FrmDone),
        .o_Busy         (o_Busy),
        .o_ErrDupDone   (o_ErrDupDone)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_FrmStartVld  = 1'b0;
        i_JobRdy       = 1'b0;
        i_DoneVld      = 1'b0;
        i_DonePosX     = 2'd0;
        i_DonePosY     = 2'd0;
        i_FlushVld     = 1'b0;
        i_FlushBlkXMsk = 4'h0;
        i_FlushBlkYMsk = 4'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        i_Reset = 1'b1;
        tick();
        tick();
        i_Reset = 1'b0;
    endtask

    task automatic send_done(input logic [1:0] x, input logic [1:0] y);
        i_DoneVld  = 1'b1;
        i_DonePosX = x;
        i_DonePosY = y;
        tick();
        i_DoneVld  = 1'b0;
    endtask

    // Drives one frame with JobRdy=1, completes each job one cycle after its
    // issue and flushes each row one cycle after its last completion. The last
    // row's flush uses last_xmsk so a partial flush can leave bits behind.
    task automatic run_frame(input logic [3:0] last_xmsk, input int ncyc,
                             output int n_fd, output int n_jobs,
                             output int n_order_bad, output logic rdy_after_fd);
        int   ex;
        int   ey;
        int   frow;
        int   dx;
        int   dy;
        int   qx[$];
        int   qy[$];
        logic prev_fd;
        ex = 0; ey = 0; frow = -1;
        n_fd = 0; n_jobs = 0; n_order_bad = 0;
        rdy_after_fd = 1'b0; prev_fd = 1'b0;
        i_FrmStartVld = 1'b1;
        tick();
        i_FrmStartVld = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (prev_fd) rdy_after_fd = o_FrmStartRdy;
            prev_fd = o_FrmDone;
            if (o_FrmDone) n_fd++;
            i_DoneVld  = 1'b0;
            i_FlushVld = 1'b0;
            if (frow >= 0) begin
                i_FlushVld     = 1'b1;
                i_FlushBlkYMsk = 4'b0001 << frow;
                i_FlushBlkXMsk = (frow == 3) ? last_xmsk : 4'hF;
                frow = -1;
            end
            if (qx.size() > 0) begin
                dx = qx.pop_front();
                dy = qy.pop_front();
                i_DoneVld  = 1'b1;
                i_DonePosX = 2'(dx);
                i_DonePosY = 2'(dy);
                if (dx == 3) frow = dy;
            end
            if (o_JobVld) begin
                if (o_JobPosX !== 2'(ex) || o_JobPosY !== 2'(ey)) n_order_bad++;
                qx.push_back(ex);
                qy.push_back(ey);
                n_jobs++;
                ex++;
                if (ex == 4) begin ex = 0; ey++; end
            end
            i_JobRdy = 1'b1;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (o_FrmStartRdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", o_FrmStartRdy); end
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL reset_jobvld got=%b want=0", o_JobVld); end
        total++; if (o_FrmDone !== 1'b0) begin bad++; $display("FAIL reset_frmdone got=%b want=0", o_FrmDone); end
        total++; if (o_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_Busy); end
        total++; if (o_ErrDupDone !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", o_ErrDupDone); end
        total++; if ({o_JobPosY, o_JobPosX} !== 4'h0) begin bad++; $display("FAIL reset_pos got=%h want=0", {o_JobPosY, o_JobPosX}); end
        for (int y = 0; y < 4; y++) begin
            total++; if (o_BlkIsExec[y] !== 4'h0) begin bad++; $display("FAIL reset_blk row%0d got=%b want=0000", y, o_BlkIsExec[y]); end
        end
    endtask

    task automatic test_credit_limit;
        i_FrmStartVld = 1'b1;
        tick();
        i_FrmStartVld = 1'b0;
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX} !== 5'b1_00_00) begin bad++; $display("FAIL first_job got=%b want=10000", {o_JobVld, o_JobPosY, o_JobPosX}); end
        total++; if ({o_FrmStartRdy, o_Busy} !== 2'b01) begin bad++; $display("FAIL start_rdy_busy got=%b want=01", {o_FrmStartRdy, o_Busy}); end
        i_JobRdy = 1'b1;
        tick();
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX} !== 5'b1_00_01) begin bad++; $display("FAIL second_job got=%b want=10001", {o_JobVld, o_JobPosY, o_JobPosX}); end
        tick();
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL credit_stop got=%b want=0", o_JobVld); end
        tick();
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL credit_hold got=%b want=0", o_JobVld); end
        send_done(2'd0, 2'd0);
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX} !== 5'b1_00_10) begin bad++; $display("FAIL credit_return got=%b want=10010", {o_JobVld, o_JobPosY, o_JobPosX}); end
        total++; if (o_BlkIsExec[0] !== 4'b0001) begin bad++; $display("FAIL credit_blk got=%b want=0001", o_BlkIsExec[0]); end
    endtask

    task automatic test_backpressure;
        tick();
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL bp_credit got=%b want=0", o_JobVld); end
        i_JobRdy = 1'b0;
        send_done(2'd1, 2'd0);
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX} !== 5'b1_00_11) begin bad++; $display("FAIL bp_job30 got=%b want=10011", {o_JobVld, o_JobPosY, o_JobPosX}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if ({o_JobVld, o_JobPosY, o_JobPosX} !== 5'b1_00_11) begin bad++; $display("FAIL bp_hold%0d got=%b want=10011", i, {o_JobVld, o_JobPosY, o_JobPosX}); end
        end
        i_JobRdy = 1'b1;
        tick();
        i_JobRdy = 1'b0;
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL bp_after_hs got=%b want=0", o_JobVld); end
        send_done(2'd2, 2'd0);
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX} !== 5'b1_01_00) begin bad++; $display("FAIL bp_row_wrap got=%b want=10100", {o_JobVld, o_JobPosY, o_JobPosX}); end
        total++; if (o_BlkIsExec[0] !== 4'b0111) begin bad++; $display("FAIL bp_blk got=%b want=0111", o_BlkIsExec[0]); end
    endtask

    task automatic test_full_frame;
        int   n_fd;
        int   n_jobs;
        int   n_ob;
        logic rdy_fd;
        do_reset();
        run_frame(4'hF, 30, n_fd, n_jobs, n_ob, rdy_fd);
        total++; if (n_jobs != 16) begin bad++; $display("FAIL ff_jobs got=%0d want=16", n_jobs); end
        total++; if (n_ob != 0) begin bad++; $display("FAIL ff_raster_order got=%0d want=0", n_ob); end
        total++; if (n_fd != 1) begin bad++; $display("FAIL ff_frmdone_pulses got=%0d want=1", n_fd); end
        total++; if (rdy_fd !== 1'b1) begin bad++; $display("FAIL ff_rdy_after_done got=%b want=1", rdy_fd); end
        total++; if ({o_FrmStartRdy, o_Busy, o_ErrDupDone} !== 3'b100) begin bad++; $display("FAIL ff_end_state got=%b want=100", {o_FrmStartRdy, o_Busy, o_ErrDupDone}); end
        total++; if ((o_BlkIsExec[0] | o_BlkIsExec[1] | o_BlkIsExec[2] | o_BlkIsExec[3]) !== 4'h0) begin bad++; $display("FAIL ff_blk_clear got=%b want=0000", o_BlkIsExec[0] | o_BlkIsExec[1] | o_BlkIsExec[2] | o_BlkIsExec[3]); end
    endtask

    task automatic test_collision;
        do_reset();
        i_FrmStartVld = 1'b1;
        tick();
        i_FrmStartVld = 1'b0;
        i_JobRdy = 1'b1;
        tick();
        i_JobRdy = 1'b0;
        i_FlushVld     = 1'b1;
        i_FlushBlkXMsk = 4'b0100;
        i_FlushBlkYMsk = 4'b0010;
        send_done(2'd2, 2'd1);
        total++; if (o_BlkIsExec[1] !== 4'b0100) begin bad++; $display("FAIL coll_set_wins got=%b want=0100", o_BlkIsExec[1]); end
        total++; if (o_ErrDupDone !== 1'b0) begin bad++; $display("FAIL coll_err got=%b want=0", o_ErrDupDone); end
        tick();
        i_FlushVld = 1'b0;
        total++; if (o_BlkIsExec[1] !== 4'b0000) begin bad++; $display("FAIL coll_flush_clear got=%b want=0000", o_BlkIsExec[1]); end
        idle_inputs();
    endtask

    task automatic test_dup_done;
        do_reset();
        i_FrmStartVld = 1'b1;
        tick();
        i_FrmStartVld = 1'b0;
        i_JobRdy = 1'b1;
        tick();
        tick();
        i_JobRdy = 1'b0;
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL dup_full_credit got=%b want=0", o_JobVld); end
        send_done(2'd0, 2'd0);
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX, o_ErrDupDone} !== 6'b1_00_10_0) begin bad++; $display("FAIL dup_first got=%b want=100100", {o_JobVld, o_JobPosY, o_JobPosX, o_ErrDupDone}); end
        send_done(2'd0, 2'd0);
        total++; if (o_ErrDupDone !== 1'b1) begin bad++; $display("FAIL dup_err_set got=%b want=1", o_ErrDupDone); end
        i_JobRdy = 1'b1;
        tick();
        i_JobRdy = 1'b0;
        // Only one credit was returned, so this issue fills the limit again
        total++; if (o_JobVld !== 1'b0) begin bad++; $display("FAIL dup_no_credit got=%b want=0", o_JobVld); end
        tick();
        tick();
        total++; if (o_ErrDupDone !== 1'b1) begin bad++; $display("FAIL dup_err_sticky got=%b want=1", o_ErrDupDone); end
    endtask

    task automatic test_reset_mid_frame;
        int   n_fd;
        int   n_jobs;
        int   n_ob;
        logic rdy_fd;
        do_reset();
        run_frame(4'b0001, 30, n_fd, n_jobs, n_ob, rdy_fd);
        total++; if (n_fd != 0 || o_Busy !== 1'b1) begin bad++; $display("FAIL rm_in_drain got=fd%0d busy%b want=fd0 busy1", n_fd, o_Busy); end
        total++; if (o_BlkIsExec[3] !== 4'b1110) begin bad++; $display("FAIL rm_three_bits got=%b want=1110", o_BlkIsExec[3]); end
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        total++; if ({o_FrmStartRdy, o_JobVld, o_FrmDone, o_Busy, o_ErrDupDone} !== 5'b10000) begin bad++; $display("FAIL rm_reset_outs got=%b want=10000", {o_FrmStartRdy, o_JobVld, o_FrmDone, o_Busy, o_ErrDupDone}); end
        total++; if (o_BlkIsExec[3] !== 4'h0) begin bad++; $display("FAIL rm_blk_clear got=%b want=0000", o_BlkIsExec[3]); end
        send_done(2'd0, 2'd0);
        total++; if ({o_ErrDupDone, o_BlkIsExec[0]} !== 5'b1_0000) begin bad++; $display("FAIL rm_stale_done got=%b want=10000", {o_ErrDupDone, o_BlkIsExec[0]}); end
        i_FrmStartVld = 1'b1;
        tick();
        i_FrmStartVld = 1'b0;
        total++; if ({o_JobVld, o_JobPosY, o_JobPosX, o_Busy} !== 6'b1_00_00_1) begin bad++; $display("FAIL rm_restart got=%b want=100001", {o_JobVld, o_JobPosY, o_JobPosX, o_Busy}); end
    endtask

    initial begin
        idle_inputs();
        i_Reset = 1'b1;
        test_reset();
        test_credit_limit();
        test_backpressure();
        test_full_frame();
        test_collision();
        test_dup_done();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
